// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
//   Scanner for a 4x4 hex matrix keypad. It drives one row low at a time,
//   samples the columns near the end of each row dwell, and folds four row
//   samples into one frame result. A debounce FSM that runs once per frame
//   turns stable frame results into single key-press events. Each accepted
//   key is also shifted into a 16-bit digit register for a 7-seg driver.
//
// Parameters
//   SCAN_DIV        clock cycles each row is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical frames needed to accept a press
//                   or a release (>= 1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row[3:0]   row drive, active-low, exactly one bit low
//   col[3:0]   column sense, active-low, asynchronous to clk
//   clr        synchronous clear of num
//   key_valid  one-cycle pulse per accepted press
//   key_code   hex code of the last accepted key
//   num[15:0]  entered digits, newest digit in [3:0]
// ---------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] num
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_PRESS_CHK   = 2'd1,
        S_HELD        = 2'd2,
        S_RELEASE_CHK = 2'd3
    } state_t;

    // Number of set bits in a 16-bit vector.
    function automatic logic [4:0] f_popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Index (row*4 + col) of the lowest set bit; only meaningful when one bit is set.
    function automatic logic [3:0] f_first_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Physical key position to hex legend.
    function automatic logic [3:0] f_keymap(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_ri;
    logic [3:0]       r_sync_p0;
    logic [3:0]       r_sync_p1;
    logic [11:0]      r_acc;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_cand;
    logic             r_key_valid;
    logic [3:0]       r_key_code;
    logic [15:0]      r_num;

    logic             w_div_wrap;
    logic             w_frame_end;
    logic [15:0]      w_low;
    logic             w_is_key;
    logic [3:0]       w_key;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_div_wrap  = (r_div == DIV_LAST);
    assign w_frame_end = w_div_wrap && (r_ri == 2'd3);

    // Row 3 is not stored: its sample is used directly in the frame-end cycle.
    assign w_low     = ~{r_sync_p1, r_acc};
    assign w_is_key  = (f_popcount(w_low) == 5'd1);
    assign w_key     = f_keymap(f_first_idx(w_low));
    assign w_cnt_inc = r_cnt + 1'b1;

    assign row       = ~(4'b0001 << r_ri);
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign num       = r_num;

    // Row dwell counter and row index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_ri  <= '0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            r_ri  <= r_ri + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Column synchronizer and per-row sample accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_acc     <= '0;
        end else begin
            r_sync_p0 <= col;
            r_sync_p1 <= r_sync_p0;
            if (w_div_wrap) begin
                case (r_ri)
                    2'd0:    r_acc[3:0]  <= r_sync_p1;
                    2'd1:    r_acc[7:4]  <= r_sync_p1;
                    2'd2:    r_acc[11:8] <= r_sync_p1;
                    default: ;
                endcase
            end
        end
    end

    // Debounce FSM, evaluated once per frame, with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_num       <= '0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_key) begin
                            r_cand <= w_key;
                            r_cnt  <= CNT_W'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state     <= S_HELD;
                                r_key_valid <= 1'b1;
                                r_key_code  <= w_key;
                                r_num       <= {r_num[11:0], w_key};
                            end else begin
                                r_state <= S_PRESS_CHK;
                            end
                        end
                    end
                    S_PRESS_CHK: begin
                        if (w_is_key && (w_key == r_cand)) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_TGT) begin
                                r_state     <= S_HELD;
                                r_key_valid <= 1'b1;
                                r_key_code  <= r_cand;
                                r_num       <= {r_num[11:0], r_cand};
                            end
                        end else begin
                            // A different key or a gap restarts from scratch.
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    S_HELD: begin
                        // Any key result keeps us held: no auto-repeat, no roll-over.
                        if (!w_is_key) begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= (DEBOUNCE_SCANS == 1) ? S_IDLE : S_RELEASE_CHK;
                        end
                    end
                    S_RELEASE_CHK: begin
                        if (w_is_key) begin
                            r_state <= S_HELD;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == CNT_TGT) begin
                                r_state <= S_IDLE;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            // Clear takes priority over a same-cycle digit shift.
            if (clr) r_num <= '0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

    localparam int SD = 8;
    localparam int DS = 3;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] num;
    logic [15:0] mask = 16'h0000;   // pressed keys, bit = r*4 + c

    always #5 clk = ~clk;

    // Passive keypad: column c reads low while row r is driven low and key (r,c) is down.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .clr(clr),
        .key_valid(key_valid),
        .key_code(key_code),
        .num(num)
    );

    localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_run;
    int          m_none;
    bit          m_held;
    logic [3:0]  m_run_key;
    logic [3:0]  m_code;
    logic [15:0] m_num;
    int          seg_pulses;

    typedef struct {
        logic [15:0] mask;
        int          frames;
        bit          do_clr;
        int          pulses;
        logic [15:0] num;
        logic [3:0]  code;
    } seg_t;

    seg_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_none = 0; m_held = 0;
        m_run_key = 4'h0; m_code = 4'h0; m_num = 16'h0000;
    endfunction

    // One frame of the debounce rules, in terms of run lengths of identical results.
    function automatic void model_frame(input logic [15:0] m, output bit acc, output logic [3:0] k);
        bit is_key;
        is_key = ($countones(m) == 1);
        k = 4'h0;
        for (int i = 0; i < 16; i++) if (m[i]) k = KMAP[i];
        acc = 0;
        if (!m_held) begin
            if (!is_key)               m_run = 0;
            else if (m_run == 0)       begin m_run_key = k; m_run = 1; end
            else if (k == m_run_key)   m_run++;
            else                       m_run = 0;
            if (m_run == DS) begin
                acc = 1; m_held = 1; m_run = 0; m_none = 0;
            end
        end else begin
            if (is_key) m_none = 0;
            else begin
                m_none++;
                if (m_none == DS) begin m_held = 0; m_none = 0; end
            end
        end
    endfunction

    function automatic logic [3:0] exp_row(input int j);
        logic [3:0] r;
        r = ~(4'b0001 << ((j % FRAME) / SD));
        return r;
    endfunction

    // Runs one full frame from cycle 0 with key mask m; clr is high during cycle clr_cyc (-1: never).
    task automatic run_frame(input logic [15:0] m, input int clr_cyc);
        bit         acc;
        bit         was_clr;
        logic [3:0] k;
        mask = m;
        for (int j = 1; j <= FRAME; j++) begin
            if (clr_cyc == j - 1) clr = 1'b1;
            @(posedge clk);
            #1;
            was_clr = clr;
            clr = 1'b0;
            acc = 0;
            if (j == FRAME) begin
                model_frame(m, acc, k);
                if (acc) begin
                    m_code = k;
                    m_num  = {m_num[11:0], k};
                end
            end
            if (was_clr) m_num = 16'h0000;
            if (key_valid) seg_pulses++;
            chk("row", {12'd0, row}, {12'd0, exp_row(j)});
            chk("key_valid", {15'd0, key_valid}, {15'd0, acc});
            chk("key_code", {12'd0, key_code}, {12'd0, m_code});
            chk("num", num, m_num);
        end
    endtask

    function automatic void add_seg(input logic [15:0] m, input int f, input bit c,
                                    input int p, input logic [15:0] n, input logic [3:0] kc);
        seg_t s;
        s.mask = m; s.frames = f; s.do_clr = c; s.pulses = p; s.num = n; s.code = kc;
        tbl.push_back(s);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_row"}, {12'd0, row}, 16'h000E);
        chk({tag, "_kv"}, {15'd0, key_valid}, 16'h0000);
        chk({tag, "_code"}, {12'd0, key_code}, 16'h0000);
        chk({tag, "_num"}, num, 16'h0000);
    endtask

    initial begin
        logic [15:0] rm;
        int          rsel;
        int          a;
        int          b;
        int          nf;
        int          cc;

        // Directed segments: mask, frames, clr at start, pulses, num after, key_code after
        add_seg(16'h0000, 4, 0, 0, 16'h0000, 4'h0);  // idle scan
        add_seg(16'h0040, 5, 0, 1, 16'h0006, 4'h6);  // hold 6
        add_seg(16'h0000, 4, 0, 0, 16'h0006, 4'h6);
        add_seg(16'h0001, 4, 1, 1, 16'h0001, 4'h1);  // 1 after clear
        add_seg(16'h0000, 4, 0, 0, 16'h0001, 4'h1);
        add_seg(16'h0002, 4, 0, 1, 16'h0012, 4'h2);
        add_seg(16'h0000, 4, 0, 0, 16'h0012, 4'h2);
        add_seg(16'h0004, 4, 0, 1, 16'h0123, 4'h3);
        add_seg(16'h0000, 4, 0, 0, 16'h0123, 4'h3);
        add_seg(16'h0010, 4, 0, 1, 16'h1234, 4'h4);
        add_seg(16'h0000, 4, 0, 0, 16'h1234, 4'h4);
        add_seg(16'h0020, 4, 0, 1, 16'h2345, 4'h5);
        add_seg(16'h0000, 4, 0, 0, 16'h2345, 4'h5);
        add_seg(16'h0400, 2, 0, 0, 16'h2345, 4'h5);  // bouncing 9
        add_seg(16'h0000, 1, 0, 0, 16'h2345, 4'h5);
        add_seg(16'h0400, 1, 0, 0, 16'h2345, 4'h5);
        add_seg(16'h0000, 4, 0, 0, 16'h2345, 4'h5);
        add_seg(16'h0220, 4, 0, 0, 16'h2345, 4'h5);  // 5 and 8 together
        add_seg(16'h0000, 4, 0, 0, 16'h2345, 4'h5);
        add_seg(16'h0100, 4, 0, 1, 16'h3457, 4'h7);  // 7 with release bounce
        add_seg(16'h0000, 1, 0, 0, 16'h3457, 4'h7);
        add_seg(16'h0100, 3, 0, 0, 16'h3457, 4'h7);
        add_seg(16'h0000, 4, 0, 0, 16'h3457, 4'h7);

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < tbl.size(); s++) begin
            seg_pulses = 0;
            for (int f = 0; f < tbl[s].frames; f++) begin
                run_frame(tbl[s].mask, (tbl[s].do_clr && f == 0) ? 0 : -1);
            end
            chk($sformatf("seg%0d_pulses", s), 16'(seg_pulses), 16'(tbl[s].pulses));
            chk($sformatf("seg%0d_num", s), num, tbl[s].num);
            chk($sformatf("seg%0d_code", s), {12'd0, key_code}, {12'd0, tbl[s].code});
        end

        // clr in the very cycle an A press is accepted
        run_frame(16'h0008, -1);
        run_frame(16'h0008, -1);
        run_frame(16'h0008, FRAME - 1);
        chk("clr_acc_kv", {15'd0, key_valid}, 16'h0001);
        chk("clr_acc_code", {12'd0, key_code}, 16'h000A);
        chk("clr_acc_num", num, 16'h0000);
        repeat (4) run_frame(16'h0000, -1);

        // Load a digit so the reset test sees non-zero outputs
        repeat (4) run_frame(16'h0800, -1);
        repeat (4) run_frame(16'h0000, -1);
        chk("pre_rst_num", num, 16'h000C);
        chk("pre_rst_code", {12'd0, key_code}, 16'h000C);

        // Asynchronous reset in the middle of PRESS_CHK
        run_frame(16'h2000, -1);
        run_frame(16'h2000, -1);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk);
            #1;
            chk("mid_row", {12'd0, row}, {12'd0, exp_row(j)});
            chk("mid_kv", {15'd0, key_valid}, 16'h0000);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        mask = 16'h8000;
        @(negedge clk);
        rst_n = 1'b1;
        seg_pulses = 0;
        repeat (3) run_frame(16'h8000, -1);
        chk("post_rst_pulses", 16'(seg_pulses), 16'd1);
        chk("post_rst_code", {12'd0, key_code}, 16'h000D);
        chk("post_rst_num", num, 16'h000D);
        repeat (4) run_frame(16'h0000, -1);

        // Randomized segments against the reference model
        for (int s = 0; s < 40; s++) begin
            rsel = int'($urandom_range(0, 99));
            if (rsel < 40) begin
                rm = 16'h0000;
            end else if (rsel < 85) begin
                rm = 16'h0001 << $urandom_range(0, 15);
            end else begin
                a  = int'($urandom_range(0, 15));
                b  = (a + 1 + int'($urandom_range(0, 14))) % 16;
                rm = (16'h0001 << a) | (16'h0001 << b);
            end
            nf = int'($urandom_range(1, 5));
            for (int f = 0; f < nf; f++) begin
                cc = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
                run_frame(rm, cc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 hex matrix keypad scanner: the input-side counterpart of the multiplexed 7-segment display driver.
- Drives keypad rows one at a time, samples the columns, and debounces across whole scan frames.
- Each accepted key press yields a 4-bit hex code, which is also shifted into a 16-bit entry register.
- The entry register feeds the display driver's `num` input directly.

Parameters:
- SCAN_DIV, 50000, clock cycles each row is driven (dwell); must be >= 4.
- DEBOUNCE_SCANS, 3, consecutive identical frame results required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- row  output  4  row drive, active-low; exactly one bit low at all times.
- col  input  4  column sense, active-low (external pull-ups), asynchronous to clk.
- clr  input  1  synchronous clear of num.
- key_valid  output  1  one-cycle pulse when a debounced press is accepted.
- key_code  output  4  hex code of the last accepted key; holds its value between presses.
- num  output  16  entered digits; newest digit in [3:0].

Behaviour:
- Reset (rst_n low, asynchronous):
  - row=4'b1110, key_valid=0, key_code=0, num=0.
  - Dwell counter, row index, synchronizer, accumulator and debounce counter are all 0.
  - FSM goes to IDLE.
  - Asserting reset mid-press discards all progress. After release of reset the scan restarts at row 0.
- Scan:
  - Dwell counter div runs 0..SCAN_DIV-1, then wraps to 0.
  - At the wrap, row index ri advances 0->1->2->3->0.
  - row = ~(1<<ri): ri0 gives 1110, ri1 gives 1101, ri2 gives 1011, ri3 gives 0111.
- Sampling:
  - col passes through a 2-flop synchronizer.
  - The synchronized value is captured for row ri on the cycle where div==SCAN_DIV-1.
  - A pressed key reads as 0 on its column bit.
- Frame:
  - Four consecutive row samples, ri0..ri3, form one frame of 4*SCAN_DIV cycles.
  - The frame ends at the ri3 sample and produces result F:
    - no bits low gives NONE;
    - exactly one bit low across all 16 gives KEY(k);
    - two or more low (multi-key or ghosting) gives NONE.
- Key map (r=row index, c=col bit index, code in hex):
  - r0: c0=1, c1=2, c2=3, c3=A
  - r1: c0=4, c1=5, c2=6, c3=B
  - r2: c0=7, c1=8, c2=9, c3=C
  - r3: c0=E, c1=0, c2=F, c3=D
- Debounce FSM (evaluated only at frame end; cnt is the debounce counter, cand the candidate code):
  - IDLE:
    - F=KEY(k): cand=k, cnt=1. If DEBOUNCE_SCANS==1, accept immediately and go to HELD; otherwise go to PRESS_CHK.
    - F=NONE: stay in IDLE.
  - PRESS_CHK:
    - F=KEY(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - Any other F: go to IDLE, cnt=0.
  - HELD:
    - F=NONE: cnt=1, go to RELEASE_CHK. If DEBOUNCE_SCANS==1, go straight to IDLE.
    - F=KEY(any): stay in HELD. There is no auto-repeat, and a different key while held is ignored.
  - RELEASE_CHK:
    - F=NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - F=KEY(any): go to HELD.
- Accept (registered on the edge ending the frame-end cycle T):
  - key_valid=1 in cycle T+1 only.
  - key_code=cand.
  - num={num[11:0], cand}; the oldest digit is dropped.
- Latency: key_valid rises 1 cycle after the ri3 sample of the DEBOUNCE_SCANS-th consecutive matching frame.
- clr:
  - num=0 on the next edge.
  - FSM, key_code and key_valid are unaffected.
  - clr in the same cycle as an accept: clr wins (num=0); key_valid still pulses and key_code still updates.
- Widths: num shift is a pure 16-bit shift with no arithmetic; cnt is wide enough to hold DEBOUNCE_SCANS without overflow.

Test Plan (SCAN_DIV=8, DEBOUNCE_SCANS=3, frame=32 cycles; col model returns 0 on column c only while row bit r is low):
- Reset, no keys, 100 cycles:
  - row cycles 1110->1101->1011->0111 every 8 cycles.
  - key_valid never asserts; num=0000.
- Hold key r1c2 (6) steadily:
  - exactly one key_valid pulse, 1 cycle after the ri3 sample of the 3rd frame;
  - key_code=6, num=0006;
  - no further pulses while held.
- Press 1, release, then 2, 3, 4, 5, each held 4 frames with 4 released frames between:
  - num goes 0001, 0012, 0123, 1234, then 2345;
  - five pulses in total.
- Bounce: key 9 present for 2 frames, absent for 1, present for 1, then released:
  - no key_valid; FSM returns to IDLE.
- Ghost/multi-key and release bounce:
  - holding 5 and 8 together gives no pulse;
  - holding 7, then a 1-frame release gap, then 7 again gives one pulse only (RELEASE_CHK->HELD).
- clr and reset:
  - clr asserted in the accept cycle of key A: num=0000, key_valid=1, key_code=A;
  - rst_n low mid-PRESS_CHK: all outputs return to reset values immediately, without waiting for a clock edge.
